// File: rtl/sram_port_client.sv
// Single-port SRAM client: holds each access on the arbiter port for HOLD_CYCLES
// cycles, separates accesses by one DONE cycle, and buffers one extra command.
module sram_port_client #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [18:0] mem_a,
  output logic        mem_we_n,
  output logic        mem_oe_n,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [18:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        pend_q, pend_d;
  logic [18:0] paddr_q, paddr_d;
  logic        pwe_q, pwe_d;
  logic [7:0]  pwdata_q, pwdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        accept;
  logic        last;

  assign req_ready = ~pend_q;
  assign accept    = req_valid & ~pend_q;
  assign last      = (cnt_q == 4'(HOLD_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    pend_d   = pend_q;
    paddr_d  = paddr_q;
    pwe_d    = pwe_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (accept) begin
          pend_d   = 1'b1;
          paddr_d  = req_addr;
          pwe_d    = req_we;
          pwdata_d = req_wdata;
        end
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) rdata_d = mem_dout;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // A buffered command always wins; a new one can only be accepted when PEND is empty.
        if (pend_q) begin
          addr_d  = paddr_q;
          we_d    = pwe_q;
          wdata_d = pwdata_q;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      pend_q   <= 1'b0;
      paddr_q  <= '0;
      pwe_q    <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      pend_q   <= pend_d;
      paddr_q  <= paddr_d;
      pwe_q    <= pwe_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Strobes decode straight from state so reset releases them without a clock edge.
  assign mem_a     = addr_q;
  assign mem_din   = wdata_q;
  assign mem_we_n  = ~((state_q == ACCESS) & we_q);
  assign mem_oe_n  = ~((state_q == ACCESS) & ~we_q);
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_port_client.sv
// Self-checking bench for sram_port_client: scoreboard for responses, per-cycle
// history for port timing, plus a second instance at HOLD_CYCLES=15.
module tb_sram_port_client;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [18:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [18:0] mem_a;
  logic        mem_we_n, mem_oe_n;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = '0;

  logic        v15 = 1'b0, rdy15, rv15, we_n15, oe_n15;
  logic [7:0]  rd15, din15;
  logic [7:0]  dout15 = '0;
  logic [18:0] a15;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_count = 0;

  typedef struct {logic we; logic [7:0] d;} exp_t;
  exp_t sb_q[$];
  logic [7:0] gold [logic [18:0]];
  logic [7:0] tmem [logic [18:0]];
  logic [7:0] last_rd = 8'h00;
  logic slot = 1'b0;

  logic        h_we [4096];
  logic        h_oe [4096];
  logic        h_rv [4096];
  logic        h_rdy [4096];
  logic [18:0] h_a [4096];
  logic [7:0]  h_rd [4096];

  sram_port_client #(.HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_a(mem_a),
    .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  sram_port_client #(.HOLD_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .req_valid(v15), .req_ready(rdy15),
    .req_we(1'b0), .req_addr(19'h7ABCD), .req_wdata(8'h00),
    .rsp_valid(rv15), .rsp_rdata(rd15), .mem_a(a15),
    .mem_we_n(we_n15), .mem_oe_n(oe_n15), .mem_din(din15), .mem_dout(dout15)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: writes on every strobed edge, read data registered on alternate edges.
  always @(posedge clk) begin
    slot <= ~slot;
    if (mem_we_n == 1'b0) tmem[mem_a] = mem_din;
    if (slot && mem_oe_n == 1'b0) mem_dout <= tmem.exists(mem_a) ? tmem[mem_a] : 8'h00;
    dout15 <= a15[7:0] ^ 8'h5A;
  end

  always @(negedge clk) begin
    exp_t e;
    h_we[cyc % 4096]  = mem_we_n;
    h_oe[cyc % 4096]  = mem_oe_n;
    h_rv[cyc % 4096]  = rsp_valid;
    h_rdy[cyc % 4096] = req_ready;
    h_a[cyc % 4096]   = mem_a;
    h_rd[cyc % 4096]  = rsp_rdata;
    if (rsp_valid === 1'b1) begin
      rsp_count++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_rsp cyc=%0d rdata=%h expected no response", cyc, rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        if (!e.we) last_rd = e.d;
        if (rsp_rdata !== last_rd) begin
          bad++;
          $display("FAIL sb_rdata we=%0b got=%h exp=%h", e.we, rsp_rdata, last_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Drives one command (starting at a negedge) and waits for its acceptance edge.
  // Returns t = history index of the first cycle after acceptance; req_valid stays high.
  task automatic send(input logic we, input logic [18:0] a, input logic [7:0] d, output int t);
    logic acc;
    exp_t e;
    acc = 1'b0;
    t = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = req_ready;
      @(posedge clk);
      if (acc) begin
        e.we = we;
        e.d  = we ? d : (gold.exists(a) ? gold[a] : 8'h00);
        if (we) gold[a] = d;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_timeout addr=%h got=no_accept exp=accept", a);
    end else begin
      t = cyc;
    end
  endtask

  task automatic idle_wait(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, mem_a, mem_din, mem_we_n, mem_oe_n} !==
        {1'b1, 1'b0, 8'h00, 19'h0, 8'h00, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h a=%h din=%h we_n=%b oe_n=%b exp 1 0 00 0 00 1 1",
               req_ready, rsp_valid, rsp_rdata, mem_a, mem_din, mem_we_n, mem_oe_n);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    int c, t, t0;
    c = cyc;
    send(1'b1, 19'h12345, 8'hA5, t);
    idle_wait(8);
    total++;
    if (t !== c + 1) begin
      bad++;
      $display("FAIL first_accept_edge got=%0d exp=%0d", t, c + 1);
    end
    t0 = t - 1;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (h_we[(t0 + k) % 4096] !== (k > 3) || h_rv[(t0 + k) % 4096] !== (k == 4)) begin
        bad++;
        $display("FAIL wr_timing cycle=%0d got we_n=%b rv=%b exp we_n=%b rv=%b", k,
                 h_we[(t0 + k) % 4096], h_rv[(t0 + k) % 4096], (k > 3), (k == 4));
      end
      if (k <= 3) begin
        total++;
        if (h_a[(t0 + k) % 4096] !== 19'h12345) begin
          bad++;
          $display("FAIL wr_addr cycle=%0d got=%h exp=12345", k, h_a[(t0 + k) % 4096]);
        end
      end
    end
  endtask

  task automatic test_read_back;
    int t, t0;
    send(1'b0, 19'h12345, 8'h00, t);
    idle_wait(8);
    t0 = t - 1;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (h_oe[(t0 + k) % 4096] !== (k == 4) || h_rv[(t0 + k) % 4096] !== (k == 4)) begin
        bad++;
        $display("FAIL rd_timing cycle=%0d got oe_n=%b rv=%b exp oe_n=%b rv=%b", k,
                 h_oe[(t0 + k) % 4096], h_rv[(t0 + k) % 4096], (k == 4), (k == 4));
      end
    end
    total++;
    if (h_rd[(t0 + 4) % 4096] !== 8'hA5) begin
      bad++;
      $display("FAIL rd_data got=%h exp=a5", h_rd[(t0 + 4) % 4096]);
    end
  endtask

  task automatic test_pipelined;
    int t, t2, t0;
    send(1'b1, 19'h00010, 8'h11, t);
    send(1'b0, 19'h00020, 8'h00, t2);
    idle_wait(12);
    t0 = t - 1;
    total++;
    if (t2 !== t + 1) begin
      bad++;
      $display("FAIL pipe_second_accept got=%0d exp=%0d", t2, t + 1);
    end
    for (int k = 1; k <= 9; k++) begin
      total++;
      if (h_rv[(t0 + k) % 4096] !== (k == 4 || k == 8)) begin
        bad++;
        $display("FAIL pipe_rsp cycle=%0d got=%b exp=%b", k, h_rv[(t0 + k) % 4096], (k == 4 || k == 8));
      end
      if (k >= 2 && k <= 5) begin
        total++;
        if (h_rdy[(t0 + k) % 4096] !== (k == 5)) begin
          bad++;
          $display("FAIL pipe_ready cycle=%0d got=%b exp=%b", k, h_rdy[(t0 + k) % 4096], (k == 5));
        end
      end
      if (k >= 5 && k <= 7) begin
        total++;
        if (h_oe[(t0 + k) % 4096] !== 1'b0 || h_a[(t0 + k) % 4096] !== 19'h00020) begin
          bad++;
          $display("FAIL pipe_access2 cycle=%0d got oe_n=%b a=%h exp oe_n=0 a=00020", k,
                   h_oe[(t0 + k) % 4096], h_a[(t0 + k) % 4096]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int t, tf, c0;
    c0 = rsp_count;
    send(1'b1, 19'h00100, 8'hC0, tf);
    for (int i = 1; i < 4; i++) send(1'b1, 19'h00100 + 19'(i), 8'hC0 + 8'(i), t);
    idle_wait(20);
    for (int k = 1; k <= 17; k++) begin
      total++;
      if (h_we[(tf - 1 + k) % 4096] !== (k % 4 == 0 || k == 17)) begin
        bad++;
        $display("FAIL b2b_we_n cycle=%0d got=%b exp=%b", k, h_we[(tf - 1 + k) % 4096],
                 (k % 4 == 0 || k == 17));
      end
    end
    total++;
    if (rsp_count - c0 !== 4) begin
      bad++;
      $display("FAIL b2b_rsp_count got=%0d exp=4", rsp_count - c0);
    end
  endtask

  task automatic test_reset_mid_write;
    int t, c0;
    send(1'b1, 19'h0ABCD, 8'h77, t);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (mem_we_n !== 1'b0) begin
      bad++;
      $display("FAIL midrst_pre_we_n got=%b exp=0", mem_we_n);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_we_n !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_a !== 19'h0) begin
      bad++;
      $display("FAIL midrst_async got we_n=%b rdy=%b rv=%b a=%h exp 1 1 0 00000",
               mem_we_n, req_ready, rsp_valid, mem_a);
    end
    sb_q.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = rsp_count;
    repeat (20) @(negedge clk);
    total++;
    if (rsp_count !== c0) begin
      bad++;
      $display("FAIL midrst_no_rsp got=%0d exp=0", rsp_count - c0);
    end
  endtask

  task automatic test_hold15;
    v15 = 1'b1;
    total++;
    if (rdy15 !== 1'b1) begin
      bad++;
      $display("FAIL h15_ready got=%b exp=1", rdy15);
    end
    @(posedge clk);
    @(negedge clk);
    v15 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      total++;
      if (oe_n15 !== (k > 15) || rv15 !== (k == 16)) begin
        bad++;
        $display("FAIL h15_timing cycle=%0d got oe_n=%b rv=%b exp oe_n=%b rv=%b",
                 k, oe_n15, rv15, (k > 15), (k == 16));
      end
      if (k == 16) begin
        total++;
        if (rd15 !== 8'h97) begin
          bad++;
          $display("FAIL h15_rdata got=%h exp=97", rd15);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_back;
    test_pipelined;
    test_back_to_back;
    test_reset_mid_write;
    test_hold15;
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_client.md
SRAM_PORT_CLIENT -- requirements
Module: sram_port_client

Interface
REQ-001 Parameter: HOLD_CYCLES, default 3, number of cycles an access is held on the memory port; legal range 3..15.
REQ-002 clk  input  1  system clock, the same clock as the memory arbiter; all logic on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  requester presents a command.
REQ-005 req_ready  output  1  block can accept a command this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  19  byte address.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse for the oldest command.
REQ-010 rsp_rdata  output  8  read data; valid while rsp_valid=1 for reads.
REQ-011 mem_a  output  19  address to the arbiter port.
REQ-012 mem_we_n  output  1  active-low write strobe to the arbiter port.
REQ-013 mem_oe_n  output  1  active-low output enable to the arbiter port.
REQ-014 mem_din  output  8  write data to the arbiter port.
REQ-015 mem_dout  input  8  registered read data from the arbiter port.

Function
REQ-016 A command is accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-017 The block SHALL have FSM states IDLE, ACCESS and DONE, plus a one-entry pending buffer (PEND).
REQ-018 IDLE to ACCESS: on acceptance; the command's addr, we and wdata are latched into the active registers.
REQ-019 ACCESS: mem_a=addr and mem_din=wdata.
- Writes: mem_we_n=0, mem_oe_n=1.
- Reads: mem_we_n=1, mem_oe_n=0.
- A 4-bit counter runs HOLD_CYCLES cycles.
- All memory outputs SHALL stay stable for the whole of ACCESS.
REQ-020 On the edge ending the last ACCESS cycle:
- a read SHALL register mem_dout into rsp_rdata;
- a write SHALL leave rsp_rdata unchanged;
- the state moves to DONE.
REQ-021 DONE lasts exactly 1 cycle.
- rsp_valid=1 for that cycle only.
- mem_we_n=1, mem_oe_n=1; mem_a and mem_din are held.
REQ-022 DONE exit:
- if PEND holds a command, it moves into the active registers and the state goes to ACCESS;
- else, if an acceptance occurs in DONE, that command goes directly to ACCESS;
- otherwise the state goes to IDLE.
REQ-023 A command accepted during ACCESS is stored in PEND.
REQ-024 req_ready = NOT PEND-full; req_ready is therefore 1 in IDLE and DONE whenever PEND is empty.
REQ-025 Latency: acceptance at edge 0 gives ACCESS in cycles 1..HOLD_CYCLES and rsp_valid in cycle HOLD_CYCLES+1.
REQ-026 Back-to-back commands SHALL be separated by exactly one DONE cycle with mem_we_n=1, so no write strobe spans two addresses.
REQ-027 Responses SHALL be returned in acceptance order; at most 2 commands are outstanding.
REQ-028 IDLE outputs: mem_we_n=1, mem_oe_n=1, rsp_valid=0; mem_a and mem_din hold their last values.
REQ-029 Handshake: req_* inputs are sampled only on acceptance; changes while req_ready=0 are ignored.

Reset
REQ-030 While rst=1, outputs SHALL take these values immediately, independent of clk:
- state=IDLE, PEND empty, counter=0;
- req_ready=1, rsp_valid=0, rsp_rdata=8'h00;
- mem_a=0, mem_din=8'h00, mem_we_n=1, mem_oe_n=1.
REQ-031 Reset asserted mid-ACCESS SHALL abort the access and deassert mem_we_n within the same cycle; no response is issued for aborted or pending commands.
REQ-032 The first acceptance is permitted on the first rising edge after rst deasserts.

Verification
REQ-033 Single write, HOLD_CYCLES=3: write addr 19'h12345 data 8'hA5 at edge 0.
- mem_we_n=0 and mem_a=19'h12345 in cycles 1-3.
- rsp_valid=1 in cycle 4 only.
REQ-034 Read-back: read 19'h12345 with a memory model returning 8'hA5 registered on alternating-slot edges.
- rsp_rdata=8'hA5 while rsp_valid=1 in cycle 4.
- mem_oe_n=0 in cycles 1-3.
REQ-035 Pipelined commands: write 19'h00010/8'h11, then read 19'h00020 accepted in cycle 1.
- req_ready=0 from cycle 2 until the DONE cycle (cycle 4).
- Second ACCESS in cycles 5-7; rsp_valid pulses in cycles 4 and 8.
REQ-036 Continuous writes: req_valid held high with 4 writes.
- Every mem_we_n low period is exactly 3 cycles, each separated by 1 high cycle.
- Exactly 4 rsp_valid pulses, in order.
REQ-037 Reset mid-write: assert rst in cycle 2 of a write.
- mem_we_n=1 and req_ready=1 with no clock edge.
- No rsp_valid pulse after deassertion.
REQ-038 Parameter corner: HOLD_CYCLES=15 read gives rsp_valid exactly at cycle 16, and the counter does not wrap early.
